flags_cond: RTL and testbench

- Flag-consumer end of the 8-bit add/sub datapath.
- Captures the cf/ovf/sf/zf outputs of the adder/subtractor into an architectural flag register.
- Evaluates 4-bit condition codes against those flags through a valid/ready request/response handshake.
- Sits between the ALU and the branch/compare-select logic. Results are registered, with a one-entry output buffer.

---
 rtl/flags_cond_pkg.sv | 34 +++
 rtl/flags_cond_cc_eval.sv | 53 +++++
 rtl/flags_cond.sv | 115 +++++++++++
 tb/tb_flags_cond.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/flags_cond_pkg.sv
// flags_cond_pkg
//   Shared constants for the flag-consumer end of the 8-bit add/sub datapath.
//   Holds the condition-code encodings (CC_EQ .. CC_NV), the bit positions
//   of each flag inside the {cf, ovf, sf, zf} flag vector, and the field widths.
//   No ports; imported by flags_cond and cc_eval.
package flags_cond_pkg;

    localparam int CC_W  = 4;
    localparam int FLG_W = 4;

    // Flag vector bit positions: {cf, ovf, sf, zf}
    localparam int FLG_CF  = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_SF  = 1;
    localparam int FLG_ZF  = 0;

    localparam logic [CC_W-1:0] CC_EQ = 4'd0;
    localparam logic [CC_W-1:0] CC_NE = 4'd1;
    localparam logic [CC_W-1:0] CC_B  = 4'd2;
    localparam logic [CC_W-1:0] CC_AE = 4'd3;
    localparam logic [CC_W-1:0] CC_BE = 4'd4;
    localparam logic [CC_W-1:0] CC_A  = 4'd5;
    localparam logic [CC_W-1:0] CC_LT = 4'd6;
    localparam logic [CC_W-1:0] CC_GE = 4'd7;
    localparam logic [CC_W-1:0] CC_LE = 4'd8;
    localparam logic [CC_W-1:0] CC_GT = 4'd9;
    localparam logic [CC_W-1:0] CC_MI = 4'd10;
    localparam logic [CC_W-1:0] CC_PL = 4'd11;
    localparam logic [CC_W-1:0] CC_VS = 4'd12;
    localparam logic [CC_W-1:0] CC_VC = 4'd13;
    localparam logic [CC_W-1:0] CC_AL = 4'd14;
    localparam logic [CC_W-1:0] CC_NV = 4'd15;

endpackage

// File: rtl/flags_cond_cc_eval.sv
// cc_eval
//   Purely combinational condition-code evaluator, shared with the branch unit.
//   Ports:
//     i_cond_code [CC_W-1:0]  : condition to evaluate (CC_* encodings)
//     i_flags     [FLG_W-1:0] : flag vector {cf, ovf, sf, zf}
//     o_taken                 : condition is true for the given flags
module cc_eval #(
    parameter int CC_W  = 4,
    parameter int FLG_W = 4
) (
    input  logic [CC_W-1:0]  i_cond_code,
    input  logic [FLG_W-1:0] i_flags,
    output logic             o_taken
);
    import flags_cond_pkg::*;

    logic w_cf;
    logic w_ovf;
    logic w_sf;
    logic w_zf;
    logic w_lt;

    assign w_cf  = i_flags[FLG_CF];
    assign w_ovf = i_flags[FLG_OVF];
    assign w_sf  = i_flags[FLG_SF];
    assign w_zf  = i_flags[FLG_ZF];
    // Signed less-than: the sign bit is only trustworthy when no overflow occurred.
    assign w_lt  = w_sf ^ w_ovf;

    always_comb begin
        o_taken = 1'b0;
        case (i_cond_code)
            CC_EQ:   o_taken = w_zf;
            CC_NE:   o_taken = !w_zf;
            CC_B:    o_taken = w_cf;
            CC_AE:   o_taken = !w_cf;
            CC_BE:   o_taken = w_cf | w_zf;
            CC_A:    o_taken = !w_cf & !w_zf;
            CC_LT:   o_taken = w_lt;
            CC_GE:   o_taken = !w_lt;
            CC_LE:   o_taken = w_zf | w_lt;
            CC_GT:   o_taken = !w_zf & !w_lt;
            CC_MI:   o_taken = w_sf;
            CC_PL:   o_taken = !w_sf;
            CC_VS:   o_taken = w_ovf;
            CC_VC:   o_taken = !w_ovf;
            CC_AL:   o_taken = 1'b1;
            CC_NV:   o_taken = 1'b0;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flags_cond.sv
// flags_cond
//   Architectural flag register plus a valid/ready condition evaluator with a
//   one-entry registered result buffer (one-cycle latency, full throughput).
//   Optional sticky-overflow bit enabled by defining FLAGS_COND_STICKY_OVF_EN.
//   Ports:
//     clk, rst_n          : clock (rising edge), asynchronous active-low reset
//     flg_we              : load flag register from cf_in/ovf_in/sf_in/zf_in
//     cf_in..zf_in        : flags from the adder/subtractor
//     flg_q [FLG_W-1:0]   : flag register {cf, ovf, sf, zf}
//     cond_valid/ready    : request handshake, cond_code sampled on accept
//     cond_code [CC_W-1:0]: condition to evaluate
//     res_valid/res_ready : result handshake, taken is the result
//     sov_clr, sov        : (FLAGS_COND_STICKY_OVF_EN only) sticky overflow
module flags_cond #(
    parameter int CC_W  = 4,
    parameter int FLG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flg_we,
    input  logic             cf_in,
    input  logic             ovf_in,
    input  logic             sf_in,
    input  logic             zf_in,
    output logic [FLG_W-1:0] flg_q,
    input  logic             cond_valid,
    output logic             cond_ready,
    input  logic [CC_W-1:0]  cond_code,
    output logic             res_valid,
    input  logic             res_ready,
`ifdef FLAGS_COND_STICKY_OVF_EN
    input  logic             sov_clr,
    output logic             sov,
`endif
    output logic             taken
);
    import flags_cond_pkg::*;

    logic [FLG_W-1:0] r_flg;
    logic             r_res_valid;
    logic             r_taken;
    // Low until the first clock edge after reset release; blocks acceptance then.
    logic             r_rst_done;

    logic [FLG_W-1:0] w_flg_in;
    logic [FLG_W-1:0] w_flg_fwd;
    logic             w_accept;
    logic             w_taken;

    always_comb begin
        w_flg_in          = '0;
        w_flg_in[FLG_CF]  = cf_in;
        w_flg_in[FLG_OVF] = ovf_in;
        w_flg_in[FLG_SF]  = sf_in;
        w_flg_in[FLG_ZF]  = zf_in;
    end

    // A request in the same cycle as a flag write sees the incoming flags.
    assign w_flg_fwd  = flg_we ? w_flg_in : r_flg;

    assign cond_ready = r_rst_done && (!r_res_valid || res_ready);
    assign w_accept   = cond_valid && cond_ready;

    cc_eval #(
        .CC_W  (CC_W),
        .FLG_W (FLG_W)
    ) u_cc_eval (
        .i_cond_code (cond_code),
        .i_flags     (w_flg_fwd),
        .o_taken     (w_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flg       <= '0;
            r_res_valid <= 1'b0;
            r_taken     <= 1'b0;
            r_rst_done  <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            if (flg_we) begin
                r_flg <= w_flg_in;
            end
            // An accept overrides consumption, so back-to-back results have no bubble.
            if (w_accept) begin
                r_res_valid <= 1'b1;
                r_taken     <= w_taken;
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign flg_q     = r_flg;
    assign res_valid = r_res_valid;
    assign taken     = r_taken;

`ifdef FLAGS_COND_STICKY_OVF_EN
    logic r_sov;

    // Set has priority over clear so an overflow in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sov <= 1'b0;
        end else if (flg_we && ovf_in) begin
            r_sov <= 1'b1;
        end else if (sov_clr) begin
            r_sov <= 1'b0;
        end
    end

    assign sov = r_sov;
`endif

endmodule

// File: tb/tb_flags_cond.sv
module tb_flags_cond;
    import flags_cond_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flg_we;
    logic       cf_in, ovf_in, sf_in, zf_in;
    logic [3:0] flg_q;
    logic       cond_valid;
    logic       cond_ready;
    logic [3:0] cond_code;
    logic       res_valid;
    logic       res_ready;
    logic       taken;
`ifdef FLAGS_COND_STICKY_OVF_EN
    logic       sov_clr;
    logic       sov;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    flags_cond dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flg_we     (flg_we),
        .cf_in      (cf_in),
        .ovf_in     (ovf_in),
        .sf_in      (sf_in),
        .zf_in      (zf_in),
        .flg_q      (flg_q),
        .cond_valid (cond_valid),
        .cond_ready (cond_ready),
        .cond_code  (cond_code),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
`ifdef FLAGS_COND_STICKY_OVF_EN
        .sov_clr    (sov_clr),
        .sov        (sov),
`endif
        .taken      (taken)
    );

    // ---------------- reference model helpers ----------------
    // Flags {cf, ovf, sf, zf} of an 8-bit add or subtract, from plain integer arithmetic.
    function automatic logic [3:0] alu(input int a, input int b, input bit sub);
        int u, s, sa, sb;
        logic [7:0] r;
        bit c, v;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        if (sub) begin
            u = a - b; s = sa - sb; c = (a < b);
        end else begin
            u = a + b; s = sa + sb; c = (u > 255);
        end
        r = u[7:0];
        v = (s > 127) || (s < -128);
        return {c, v, r[7], (r == 8'd0)};
    endfunction

    function automatic bit ref_eval(input logic [3:0] cc, input logic [3:0] f);
        bit c, v, n, z, lt;
        c = f[3]; v = f[2]; n = f[1]; z = f[0];
        lt = n ^ v;
        case (cc)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return c || z;
            4'd5:  return !c && !z;
            4'd6:  return lt;
            4'd7:  return !lt;
            4'd8:  return z || lt;
            4'd9:  return !z && !lt;
            4'd10: return n;
            4'd11: return !n;
            4'd12: return v;
            4'd13: return !v;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    bit   exp_q[$];
    bit   m_rv  = 1'b0;
    bit   m_up  = 1'b0;
    logic [3:0] m_flg = 4'h0;
    bit   m_sov = 1'b0;

    always @(negedge clk) begin
        bit exp_ready;
        logic [3:0] f;
        if (!rst_n) begin
            chk("rst_res_valid", res_valid, 0);
            chk("rst_taken", taken, 0);
            chk("rst_flg_q", flg_q, 0);
`ifdef FLAGS_COND_STICKY_OVF_EN
            chk("rst_sov", sov, 0);
`endif
            exp_q.delete();
            m_rv = 0; m_up = 0; m_flg = 4'h0; m_sov = 0;
        end else begin
            exp_ready = m_up && (!m_rv || res_ready);
            chk("cond_ready", cond_ready, exp_ready);
            chk("res_valid", res_valid, m_rv);
            chk("flg_q", flg_q, m_flg);
            if (m_rv) begin
                if (exp_q.size() == 0) chk("sb_empty", 1, 0);
                else chk("taken", taken, exp_q[0]);
            end
`ifdef FLAGS_COND_STICKY_OVF_EN
            chk("sov", sov, m_sov);
`endif
            // advance model across the coming edge
            if (m_rv && res_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (cond_valid && exp_ready) begin
                f = flg_we ? {cf_in, ovf_in, sf_in, zf_in} : m_flg;
                exp_q.push_back(ref_eval(cond_code, f));
                m_rv = 1;
            end else if (res_ready) begin
                m_rv = 0;
            end
            if (flg_we) m_flg = {cf_in, ovf_in, sf_in, zf_in};
`ifdef FLAGS_COND_STICKY_OVF_EN
            if (flg_we && ovf_in) m_sov = 1;
            else if (sov_clr) m_sov = 0;
`endif
            m_up = 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit we, input logic [3:0] f, input bit cv,
                       input logic [3:0] cc, input bit rr);
        flg_we = we;
        {cf_in, ovf_in, sf_in, zf_in} = f;
        cond_valid = cv;
        cond_code = cc;
        res_ready = rr;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 4'h0, 0, 4'h0, 1);
    endtask

    initial begin
        logic [3:0] seq_a[5];
        logic [3:0] seq_b[4];
        logic [3:0] seq_c[4];
        rst_n = 1'b0;
        flg_we = 0; {cf_in, ovf_in, sf_in, zf_in} = 4'h0;
        cond_valid = 0; cond_code = 4'h0; res_ready = 1;
`ifdef FLAGS_COND_STICKY_OVF_EN
        sov_clr = 0;
`endif
        repeat (3) tick();
        rst_n = 1'b1;
        idle(2);

        // 0x16 - 0x12: all flags clear
        seq_a = '{CC_GT, CC_NE, CC_AE, CC_EQ, CC_LT};
        drv(1, alu(8'h16, 8'h12, 1), 0, 4'h0, 1);
        for (int i = 0; i < 5; i++) drv(0, 4'h0, 1, seq_a[i], 1);
        idle(1);

        // 0x7F + 0x02: signed overflow, negative
        seq_b = '{CC_VS, CC_MI, CC_LT, CC_GE};
        drv(1, alu(8'h7F, 8'h02, 0), 0, 4'h0, 1);
        for (int i = 0; i < 4; i++) drv(0, 4'h0, 1, seq_b[i], 1);
        idle(2);
`ifdef FLAGS_COND_STICKY_OVF_EN
        sov_clr = 1; tick(); sov_clr = 0;
        idle(1);
`endif

        // 0xFE - 0xFF: borrow, negative
        seq_c = '{CC_B, CC_LT, CC_A, CC_BE};
        drv(1, alu(8'hFE, 8'hFF, 1), 0, 4'h0, 1);
        for (int i = 0; i < 4; i++) drv(0, 4'h0, 1, seq_c[i], 1);
        idle(1);

        // flag write and EQ request in the same cycle: forwarding
        drv(1, alu(8'h16, 8'h16, 1), 1, CC_EQ, 1);
        idle(2);

        // backpressure then back-to-back drain
        for (int i = 0; i < 4; i++) drv(0, 4'h0, 1, CC_AL, 0);
        for (int i = 0; i < 4; i++) drv(0, 4'h0, 1, 4'(i + 8), 1);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [3:0] f;
            if ($urandom_range(1, 0) == 1)
                f = alu($urandom_range(255, 0), $urandom_range(255, 0), 1'($urandom_range(1, 0)));
            else
                f = 4'($urandom_range(15, 0));
`ifdef FLAGS_COND_STICKY_OVF_EN
            sov_clr = ($urandom_range(7, 0) == 0);
`endif
            drv(($urandom_range(3, 0) == 0), f, ($urandom_range(3, 0) != 0),
                4'($urandom_range(15, 0)), ($urandom_range(3, 0) != 0));
        end
`ifdef FLAGS_COND_STICKY_OVF_EN
        sov_clr = 0;
`endif
        idle(2);

        // reset while a result is held
        drv(1, 4'hF, 1, CC_AL, 0);
        drv(0, 4'h0, 0, 4'h0, 0);
        rst_n = 1'b0;
        tick();
        drv(0, 4'h0, 1, CC_AL, 1);
        rst_n = 1'b1;
        // request pending across release: must not be taken on the first edge
        drv(0, 4'h0, 1, CC_NV, 1);
        drv(0, 4'h0, 0, 4'h0, 1);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
